// File: rtl/osd_alpha_fader.sv
// OSD alpha fader: ramps a 0..256 blend coefficient up/down in fixed steps,
// updating only on vsync rising edges so the overlay never tears mid-frame.
module osd_alpha_fader #(
    parameter int STEP            = 16,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       osd_enable,
    input  logic       instant,
    output logic [8:0] alpha,
    output logic       osd_active,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    localparam logic [9:0] STEP_W   = 10'(STEP);
    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [8:0] ALPHA_MAX = 9'd256;

    state_t      state, nxt_state;
    logic [8:0]  nxt_alpha;
    logic [7:0]  cnt, nxt_cnt;
    logic        vsync_q;
    logic        nxt_done;
    logic        fe, tick;
    logic [9:0]  sum;
    logic signed [9:0] diff;

    assign fe   = vsync & ~vsync_q;
    assign tick = fe & (cnt == CNT_LAST);
    assign sum  = {1'b0, alpha} + STEP_W;
    assign diff = $signed({1'b0, alpha}) - $signed(STEP_W);

    always_comb begin
        nxt_state = state;
        nxt_alpha = alpha;
        nxt_done  = 1'b0;
        nxt_cnt   = cnt;
        if (tick)
            nxt_cnt = '0;
        else if (fe)
            nxt_cnt = cnt + 8'd1;

        if (instant && fe) begin
            nxt_state = osd_enable ? SHOWN : HIDDEN;
            nxt_alpha = osd_enable ? ALPHA_MAX : '0;
            nxt_done  = (nxt_state != state);
        end else begin
            // A direction change takes precedence over a same-cycle tick.
            unique case (state)
                HIDDEN: begin
                    if (osd_enable)
                        nxt_state = FADE_IN;
                end
                FADE_IN: begin
                    if (!osd_enable) begin
                        nxt_state = FADE_OUT;
                    end else if (tick) begin
                        if (sum >= 10'd256) begin
                            nxt_alpha = ALPHA_MAX;
                            nxt_state = SHOWN;
                            nxt_done  = 1'b1;
                        end else begin
                            nxt_alpha = sum[8:0];
                        end
                    end
                end
                SHOWN: begin
                    if (!osd_enable)
                        nxt_state = FADE_OUT;
                end
                FADE_OUT: begin
                    if (osd_enable) begin
                        nxt_state = FADE_IN;
                    end else if (tick) begin
                        if (diff <= 10'sd0) begin
                            nxt_alpha = '0;
                            nxt_state = HIDDEN;
                            nxt_done  = 1'b1;
                        end else begin
                            nxt_alpha = diff[8:0];
                        end
                    end
                end
                default: nxt_state = HIDDEN;
            endcase
        end

        if (nxt_state != state || (instant && fe))
            nxt_cnt = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HIDDEN;
            alpha      <= '0;
            cnt        <= '0;
            vsync_q    <= 1'b0;
            osd_active <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt_state;
            alpha      <= nxt_alpha;
            cnt        <= nxt_cnt;
            vsync_q    <= vsync;
            osd_active <= (nxt_alpha != '0);
            busy       <= (nxt_state == FADE_IN) || (nxt_state == FADE_OUT);
            done       <= nxt_done;
        end
    end

endmodule

// File: tb/tb_osd_alpha_fader.sv
// Directed bench for osd_alpha_fader: three instances with different STEP /
// FRAMES_PER_STEP settings share clock, reset and vsync.
module tb_osd_alpha_fader;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       vsync = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic       ins_a = 1'b0, ins_b = 1'b0, ins_c = 1'b0;
    logic [8:0] alpha_a, alpha_b, alpha_c;
    logic       act_a, act_b, act_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    int total = 0;
    int bad   = 0;
    int nd_a  = 0;
    int nd_b  = 0;
    int nd_base;

    always #5 clock = ~clock;

    osd_alpha_fader #(.STEP(16), .FRAMES_PER_STEP(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .osd_enable(en_a),
        .instant(ins_a), .alpha(alpha_a), .osd_active(act_a), .busy(busy_a), .done(done_a)
    );
    osd_alpha_fader #(.STEP(100), .FRAMES_PER_STEP(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .osd_enable(en_b),
        .instant(ins_b), .alpha(alpha_b), .osd_active(act_b), .busy(busy_b), .done(done_b)
    );
    osd_alpha_fader #(.STEP(16), .FRAMES_PER_STEP(1)) dut_c (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .osd_enable(en_c),
        .instant(ins_c), .alpha(alpha_c), .osd_active(act_c), .busy(busy_c), .done(done_c)
    );

    always @(posedge clock) begin
        if (done_a) nd_a <= nd_a + 1;
        if (done_b) nd_b <= nd_b + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input int hi);
        @(negedge clock) vsync = 1'b1;
        repeat (hi) @(negedge clock);
        vsync = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_alpha", alpha_a, 0);
        check("rst_active", act_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_alpha_b", alpha_b, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // STEP=16, FPS=2: one step every second frame
        en_a = 1'b1;
        @(negedge clock);
        check("a_busy_start", busy_a, 1);
        check("a_alpha_start", alpha_a, 0);
        for (int k = 1; k <= 32; k++) begin
            pulse(1);
            check($sformatf("a_alpha_p%0d", k), alpha_a, 16 * (k / 2));
        end
        check("a_done_count", nd_a, 1);
        check("a_busy_end", busy_a, 0);
        check("a_active_end", act_a, 1);

        // STEP=100, FPS=1: clamps at 256 going up and 0 going down
        en_b = 1'b1;
        @(negedge clock);
        pulse(1); check("b_up1", alpha_b, 100);
        pulse(1); check("b_up2", alpha_b, 200);
        pulse(1); check("b_up3", alpha_b, 256);
        check("b_shown_busy", busy_b, 0);
        en_b = 1'b0;
        @(negedge clock);
        check("b_out_busy", busy_b, 1);
        pulse(1); check("b_dn1", alpha_b, 156);
        pulse(1); check("b_dn2", alpha_b, 56);
        pulse(1); check("b_dn3", alpha_b, 0);
        check("b_hidden_busy", busy_b, 0);
        check("b_hidden_active", act_b, 0);
        check("b_done_count", nd_b, 2);

        // STEP=16, FPS=1: reverse at 64
        en_c = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            pulse(1);
            check($sformatf("c_up%0d", k), alpha_c, 16 * k);
        end
        en_c = 1'b0;
        @(negedge clock);
        check("c_rev_alpha", alpha_c, 64);
        check("c_rev_busy", busy_c, 1);
        for (int k = 1; k <= 4; k++) begin
            pulse(1);
            check($sformatf("c_dn%0d", k), alpha_c, 64 - 16 * k);
            check($sformatf("c_act%0d", k), act_c, (k < 4) ? 1 : 0);
        end

        // instant jump from HIDDEN
        nd_base = nd_b;
        en_b = 1'b1;
        ins_b = 1'b1;
        @(negedge clock) vsync = 1'b1;
        @(negedge clock);
        check("inst_alpha", alpha_b, 256);
        check("inst_done", done_b, 1);
        vsync = 1'b0;
        repeat (3) @(negedge clock);
        check("inst_busy", busy_b, 0);
        pulse(1);
        check("inst_alpha_hold", alpha_b, 256);
        check("inst_done_once", nd_b - nd_base, 1);

        // long vsync: one step per frame regardless of width
        en_c = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 8; k++) begin
            pulse(50);
            check($sformatf("c_long%0d", k), alpha_c, 16 * k);
        end

        // asynchronous reset mid-fade at alpha=128
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_alpha", alpha_c, 0);
        check("arst_active", act_c, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("arst_busy", busy_c, 1);
        check("arst_alpha2", alpha_c, 0);
        pulse(1);
        check("arst_restart", alpha_c, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
